// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state encodings and bit-phase constants for the I2C master
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    WRITE_DATA,
    WRITE_ACK,
    READ_DATA,
    READ_ACK,
    STOP
  } state_t;

  // Quarter-period phases of one SCL bit
  localparam logic [1:0] P0 = 2'd0;  // SCL low, SDA may change
  localparam logic [1:0] P1 = 2'd1;  // SCL released
  localparam logic [1:0] P2 = 2'd2;  // SCL high, SDA sampled at end
  localparam logic [1:0] P3 = 2'd3;  // SCL pulled low again

endpackage

// File: rtl/i2c_clk_gen.sv
// rtl/i2c_clk_gen.sv - quarter-period tick and 2-bit phase generator for SCL timing
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   clear in  restart at count 0 / phase P0 (asserted on transaction accept)
//   tick  out one-clk pulse every CLK_DIV clks
//   phase out current quarter of the SCL bit, advances on each tick
module i2c_clk_gen
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  output logic       tick,
  output logic [1:0] phase
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt   <= '0;
      phase <= P0;
    end else if (tick) begin
      cnt   <= '0;
      phase <= phase + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_master.sv
// rtl/i2c_master.sv - single-byte I2C master: START, addr+R/W, ACK, data byte, ACK/NACK, STOP
//   clk, rst             system clock, synchronous active-high reset
//   enable               request, accepted only in IDLE
//   addr, rw, data_in    transaction parameters, captured on accept
//   data_out             last byte read, updated with done on reads
//   busy                 high from accept through the end of STOP
//   done                 one-clk pulse at transaction end
//   ack_error            address or write-data NACK seen, valid with done
//   sda, scl             open-drain bus lines (drive 0 or release)
module i2c_master
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       done,
  output logic       ack_error,
  inout  wire        sda,
  inout  wire        scl
);

  state_t      state, next_state;
  logic        tick;
  logic [1:0]  phase;
  logic        accept;
  logic [2:0]  bit_cnt;
  logic [7:0]  tx_sr;
  logic [7:0]  rx_sr;
  logic [7:0]  data_reg;
  logic        rw_reg;
  logic        ack_bit;
  logic        nack_seen;
  logic        sda_low;
  logic        scl_low;
  logic        sda_in;
  logic        bit_end;
  logic        bit_scl_low;

  assign accept      = (state == IDLE) && enable;
  assign busy        = (state != IDLE);
  assign sda_in      = sda;
  assign bit_end     = tick && (phase == P3);
  assign bit_scl_low = (phase == P0) || (phase == P3);

  assign sda = sda_low ? 1'b0 : 1'bz;
  assign scl = scl_low ? 1'b0 : 1'bz;

  i2c_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .tick  (tick),
    .phase (phase)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    sda_low    = 1'b0;
    scl_low    = 1'b0;
    case (state)
      IDLE: begin
        if (enable) next_state = START;
      end
      START: begin
        // SDA falls at P2 with SCL still high, SCL follows at P3
        sda_low = (phase == P2) || (phase == P3);
        scl_low = (phase == P3);
        if (bit_end) next_state = ADDR;
      end
      ADDR, WRITE_DATA: begin
        scl_low = bit_scl_low;
        sda_low = ~tx_sr[7];
        if (bit_end && bit_cnt == 3'd0)
          next_state = (state == ADDR) ? ADDR_ACK : WRITE_ACK;
      end
      ADDR_ACK: begin
        scl_low = bit_scl_low;
        if (bit_end) begin
          if (ack_bit)     next_state = STOP;
          else if (rw_reg) next_state = READ_DATA;
          else             next_state = WRITE_DATA;
        end
      end
      WRITE_ACK, READ_ACK: begin
        scl_low = bit_scl_low;
        if (bit_end) next_state = STOP;
      end
      READ_DATA: begin
        scl_low = bit_scl_low;
        if (bit_end && bit_cnt == 3'd0) next_state = READ_ACK;
      end
      STOP: begin
        // SDA low under SCL low, SCL released, SDA released at P2, P3 is the idle tick
        scl_low = (phase == P0);
        sda_low = (phase == P0) || (phase == P1);
        if (bit_end) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= 3'd7;
      tx_sr     <= '0;
      rx_sr     <= '0;
      data_reg  <= '0;
      rw_reg    <= 1'b0;
      ack_bit   <= 1'b0;
      nack_seen <= 1'b0;
      data_out  <= '0;
      done      <= 1'b0;
      ack_error <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        tx_sr     <= {addr, rw};
        data_reg  <= data_in;
        rw_reg    <= rw;
        bit_cnt   <= 3'd7;
        nack_seen <= 1'b0;
        ack_error <= 1'b0;
      end
      if (tick) begin
        case (state)
          // Decrementing past 0 on the last bit leaves the counter at 7 for the next byte
          ADDR, WRITE_DATA: begin
            if (phase == P3) begin
              tx_sr   <= {tx_sr[6:0], 1'b0};
              bit_cnt <= bit_cnt - 3'd1;
            end
          end
          READ_DATA: begin
            if (phase == P2) rx_sr <= {rx_sr[6:0], sda_in};
            if (phase == P3) bit_cnt <= bit_cnt - 3'd1;
          end
          ADDR_ACK: begin
            if (phase == P2) ack_bit <= sda_in;
            if (phase == P3) begin
              if (ack_bit)      nack_seen <= 1'b1;
              else if (!rw_reg) tx_sr <= data_reg;
            end
          end
          WRITE_ACK: begin
            if (phase == P2) ack_bit <= sda_in;
            if (phase == P3 && ack_bit) nack_seen <= 1'b1;
          end
          STOP: begin
            if (phase == P3) begin
              done      <= 1'b1;
              ack_error <= nack_seen;
              if (rw_reg) data_out <= rx_sr;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// tb/tb_i2c_master.sv - directed bench for i2c_master with a behavioural slave at address 0x55
module tb_i2c_master;

  localparam int CLK_DIV = 4;
  localparam logic [6:0] SLV_ADDR = 7'h55;
  localparam logic [7:0] SLV_DATA = 8'hCC;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [6:0] addr = '0;
  logic       rw = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       busy, done, ack_error;
  wire        sda, scl;

  pullup (sda);
  pullup (scl);

  i2c_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .addr      (addr),
    .rw        (rw),
    .data_in   (data_in),
    .data_out  (data_out),
    .busy      (busy),
    .done      (done),
    .ack_error (ack_error),
    .sda       (sda),
    .scl       (scl)
  );

  always #5 clk = ~clk;

  logic sda_v, scl_v;
  assign sda_v = (sda !== 1'b0);
  assign scl_v = (scl !== 1'b0);

  // Behavioural slave and bus monitor, both sampling on the falling clk edge
  logic       s_low = 1'b0;
  logic       s_active = 1'b0;
  logic       s_addr_ph = 1'b0;
  logic       s_rw = 1'b0;
  logic       s_mack = 1'b0;
  logic [7:0] s_sr = '0;
  logic [7:0] s_tx = '0;
  int         s_bitn = 0;
  int         s_starts = 0;
  int         s_stops = 0;
  logic [7:0] log_byte [0:63];
  int         n_log = 0;
  logic       p_scl = 1'b1;
  logic       p_sda = 1'b1;
  int         hi_cnt = 0;
  int         lo_cnt = 0;
  logic       hi_ok = 1'b0;
  logic       lo_ok = 1'b0;
  int         proto_viol = 0;

  assign sda = s_low ? 1'b0 : 1'bz;

  always @(negedge clk) begin : slave_and_monitor
    int v;
    v = 0;
    p_scl <= scl_v;
    p_sda <= sda_v;
    if (sda === 1'bx || scl === 1'bx) v = v + 1;
    if (rst) begin
      hi_ok <= 1'b0;
      lo_ok <= 1'b0;
    end else begin
      if (scl_v && !p_scl) begin
        hi_cnt <= 1;
        hi_ok  <= 1'b1;
        if (lo_ok && lo_cnt != 2 * CLK_DIV) v = v + 1;
      end else if (scl_v) begin
        hi_cnt <= hi_cnt + 1;
      end
      if (!scl_v && p_scl) begin
        if (hi_ok && hi_cnt != 2 * CLK_DIV) v = v + 1;
        lo_cnt <= 1;
        lo_ok  <= 1'b1;
      end else if (!scl_v) begin
        lo_cnt <= lo_cnt + 1;
      end
      if (p_scl && scl_v && p_sda && !sda_v) hi_ok <= 1'b0;
    end
    proto_viol <= proto_viol + v;

    if (p_scl && scl_v && p_sda && !sda_v) begin
      s_active  <= 1'b1;
      s_addr_ph <= 1'b1;
      s_bitn    <= 0;
      s_low     <= 1'b0;
      s_starts  <= s_starts + 1;
    end else if (p_scl && scl_v && !p_sda && sda_v) begin
      s_active <= 1'b0;
      s_low    <= 1'b0;
      s_stops  <= s_stops + 1;
    end else if (s_active && !p_scl && scl_v) begin
      if (s_bitn < 8) s_sr <= {s_sr[6:0], sda_v};
      else            s_mack <= sda_v;
      s_bitn <= s_bitn + 1;
    end else if (s_active && p_scl && !scl_v) begin
      if (s_bitn == 8) begin
        if (n_log < 64) log_byte[n_log] <= s_sr;
        n_log <= n_log + 1;
        if (s_addr_ph) begin
          if (s_sr[7:1] == SLV_ADDR) begin
            s_low <= 1'b1;
            s_rw  <= s_sr[0];
          end else begin
            s_active <= 1'b0;
            s_low    <= 1'b0;
          end
        end else if (!s_rw) begin
          s_low <= 1'b1;
        end else begin
          s_low <= 1'b0;
        end
      end else if (s_bitn == 9) begin
        s_bitn    <= 0;
        s_addr_ph <= 1'b0;
        if (s_addr_ph && s_rw) begin
          s_tx  <= SLV_DATA;
          s_low <= ~SLV_DATA[7];
        end else begin
          s_low <= 1'b0;
        end
      end else if (!s_addr_ph && s_rw && s_bitn >= 1 && s_bitn <= 7) begin
        s_low <= ~s_tx[7 - s_bitn];
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse enable for one clk, then count busy samples and done samples until
  // done has been seen and ten further clks have passed (or the budget runs out)
  task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] d,
                         output int bcyc, output int dn);
    int tail;
    bcyc = 0;
    dn   = 0;
    tail = -1;
    @(negedge clk);
    addr = a; rw = r; data_in = d; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (busy) bcyc++;
      if (done) begin
        dn++;
        if (tail < 0) tail = 10;
      end
      if (tail == 0) break;
      if (tail > 0) tail--;
      @(negedge clk);
    end
  endtask

  int bc, dn, b0, st0, sp0, gap, first, dcount;
  logic ba;

  initial begin
    repeat (4) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_ack_error", ack_error, 0);
    check("reset_data_out", data_out, 8'h00);
    check("reset_sda_released", sda_v, 1);
    check("reset_scl_released", scl_v, 1);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Write 0xA5 to 0x55
    b0 = n_log; st0 = s_starts; sp0 = s_stops;
    run_txn(7'h55, 1'b0, 8'hA5, bc, dn);
    check("wr_done_pulses", dn, 1);
    check("wr_busy_cycles_in_range", (bc >= 80 * CLK_DIV - 16 && bc <= 80 * CLK_DIV + 16), 1);
    check("wr_ack_error", ack_error, 0);
    check("wr_bus_bytes", n_log - b0, 2);
    check("wr_addr_byte", log_byte[b0], 8'hAA);
    check("wr_data_byte", log_byte[b0 + 1], 8'hA5);
    check("wr_starts", s_starts - st0, 1);
    check("wr_stops", s_stops - sp0, 1);

    // Read from 0x55
    b0 = n_log; st0 = s_starts; sp0 = s_stops;
    run_txn(7'h55, 1'b1, 8'h00, bc, dn);
    check("rd_done_pulses", dn, 1);
    check("rd_data_out", data_out, 8'hCC);
    check("rd_ack_error", ack_error, 0);
    check("rd_bus_bytes", n_log - b0, 2);
    check("rd_addr_byte", log_byte[b0], 8'hAB);
    check("rd_data_byte", log_byte[b0 + 1], 8'hCC);
    check("rd_master_nack", s_mack, 1);
    check("rd_stops", s_stops - sp0, 1);

    // Wrong address: NACK, STOP, no data byte, read data held
    b0 = n_log; sp0 = s_stops;
    run_txn(7'h12, 1'b0, 8'h3C, bc, dn);
    check("na_done_pulses", dn, 1);
    check("na_ack_error", ack_error, 1);
    check("na_bus_bytes", n_log - b0, 1);
    check("na_addr_byte", log_byte[b0], 8'h24);
    check("na_stops", s_stops - sp0, 1);
    check("na_data_out_held", data_out, 8'hCC);

    // Reset in the middle of the address byte
    @(negedge clk);
    addr = 7'h55; rw = 1'b0; data_in = 8'h5A; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 2000 && !(s_active && s_addr_ph && s_bitn == 3); i++) @(negedge clk);
    check("rst_reached_addr_bit3", (s_active && s_addr_ph && s_bitn == 3), 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sda_released", sda_v, 1);
    check("rst_scl_released", scl_v, 1);
    check("rst_data_out_cleared", data_out, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    for (int i = 0; i < 400; i++) begin
      if (done) dn++;
      @(negedge clk);
    end
    check("rst_no_done", dn, 0);
    b0 = n_log;
    run_txn(7'h55, 1'b0, 8'h96, bc, dn);
    check("post_rst_done_pulses", dn, 1);
    check("post_rst_ack_error", ack_error, 0);
    check("post_rst_addr_byte", log_byte[b0], 8'hAA);
    check("post_rst_data_byte", log_byte[b0 + 1], 8'h96);

    // enable pulsed while busy (with a bad address on the inputs) is ignored
    b0 = n_log;
    @(negedge clk);
    addr = 7'h55; rw = 1'b0; data_in = 8'h0F; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    repeat (100) @(negedge clk);
    addr = 7'h12; enable = 1'b1;
    repeat (5) @(negedge clk);
    enable = 1'b0;
    dn = 0;
    for (int i = 0; i < 1000; i++) begin
      if (done) dn++;
      @(negedge clk);
    end
    check("busy_enable_done_pulses", dn, 1);
    check("busy_enable_ack_error", ack_error, 0);
    check("busy_enable_bus_bytes", n_log - b0, 2);
    check("busy_enable_data_byte", log_byte[b0 + 1], 8'h0F);

    // enable held high: back-to-back transactions
    addr = 7'h55; rw = 1'b0; data_in = 8'h81; enable = 1'b1;
    dcount = 0; first = -1; gap = -1; ba = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (dcount == 1 && i == first + 1) ba = busy;
      if (done) begin
        dcount++;
        if (dcount == 1) begin
          first = i;
        end else begin
          gap = i - first;
          enable = 1'b0;
          break;
        end
      end
    end
    enable = 1'b0;
    check("held_done_pulses", dcount, 2);
    check("held_restart_next_clk", ba, 1);
    check("held_done_gap", gap, 80 * CLK_DIV + 1);
    dn = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("held_no_third_done", dn, 0);
    check("held_idle_after", busy, 0);

    check("protocol_violations", proto_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
